spi_frame_sequencer: RTL
========================

// Module: spi_frame_sequencer
// PURPOSE
//  Parametrised SPI frame controller for the amplifier/ADC front end. Per accepted start it
//  generates SCK at a programmable rate and one active-low chip select per channel.
//  In ADC mode it first emits an ADC conversion pulse. It then clocks a DATA_W-bit frame,
//  with load/shift strobes for the external MOSI/MISO shift registers, and pulses done.
//  It sits between the top-level capture controller and the SPI shift registers.
// PARAMETERS
//  CLK_DIV     2  clk cycles per SCK half-period (>=1)
//  DATA_W      8  SCK rising edges (bits) per frame (>=1)
//  N_CH        2  number of chip selects / SPI slaves (>=1)
//  CONV_CYCLES 2  adc_conv high time in clk cycles (>=1)
//  CPOL        0  SCK idle level
//  CH_W       (localparam) max(1,$clog2(N_CH)); BIT_W = $clog2(DATA_W+1)
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       request a frame; sampled only in IDLE
//  mode      in   1       0 = ADC read (conv pulse then frame), 1 = amp config (frame only)
//  ch_sel    in   CH_W    target slave; values >= N_CH select no slave (cs stays high)
//  busy      out  1       high from the cycle after acceptance until return to IDLE
//  adc_conv  out  1       ADC conversion strobe
//  spi_sck   out  1       SPI clock
//  spi_cs_n  out  N_CH    active-low chip selects, one-hot-low while framing
//  load      out  1       1-cycle pulse: reset/load external shift registers
//  shift_en  out  1       1-cycle pulse coincident with each SCK rising (sample) edge
//  bit_idx   out  BIT_W   count of rising edges issued in the current frame
//  done      out  1       1-cycle pulse when the frame is complete
// BEHAVIOUR
//  Reset: state IDLE; busy=0, adc_conv=0, spi_sck=CPOL, spi_cs_n=all 1, load=0,
//   shift_en=0, bit_idx=0, done=0. Asserting rst mid-frame aborts on the spot (async) to these values.
//  All outputs are Moore outputs decoded from registered state/counters (glitch-free).
//  States / transitions (phase timer counts CLK_DIV or CONV_CYCLES cycles per state):
//   IDLE   -start-> (mode=0 ? CONV : LEAD); latch mode, ch_sel; load pulses on this edge's next cycle
//   CONV   adc_conv=1 for CONV_CYCLES cycles -> LEAD
//   LEAD   cs low, sck idle, CLK_DIV cycles (CS setup) -> SCK_A
//   SCK_A  sck=~CPOL for CLK_DIV cycles; shift_en on first cycle; bit_idx++ -> SCK_B
//   SCK_B  sck=CPOL for CLK_DIV cycles -> (bit_idx==DATA_W ? TAIL : SCK_A)
//   TAIL   cs low, sck idle, CLK_DIV cycles (CS hold) -> DONE
//   DONE   cs high, done=1 for exactly one cycle, busy=1 -> IDLE
//  Latency: accept edge -> done cycle = 1+[mode=0]*CONV_CYCLES+CLK_DIV*(2*DATA_W+2) cycles.
//  start while busy is ignored (no queueing); start held high restarts one cycle after DONE.
//  mode/ch_sel changes after acceptance have no effect on the current frame.
//  bit_idx saturates at DATA_W; it clears to 0 on acceptance.
//  CS is deasserted during CONV and DONE; never two cs_n bits low simultaneously.
// STRUCTURE
//  spi_seq_pkg: state encoding localparams (IDLE..DONE, 3 bits), MODE_ADC=0, MODE_AMP=1.
//  Sub-module spi_phase_timer: loadable down-counter (width $clog2(max(CLK_DIV,CONV_CYCLES))+1)
//   with load value input and 1-cycle expire output; the FSM advances on expire.
//  Top: FSM + bit counter + latched mode/ch_sel + output decode.
// TESTING (defaults unless stated)
//  mode=1, ch_sel=0, start 1 cycle -> cs_n=2'b10 for 36 cycles, 8 sck pulses 2 high/2 low,
//   8 shift_en pulses, done at cycle 37 after accept, adc_conv never high.
//  mode=0, ch_sel=1 -> adc_conv high 2 cycles with cs_n=2'b11, then cs_n=2'b01; done at cycle 39.
//  start pulsed at cycles 5 and 20 of a frame -> ignored, exactly one done, bit_idx ends at 8.
//  rst asserted after 3rd shift_en -> same cycle: cs_n=2'b11, sck=0, busy=0; next start ok.
//  CLK_DIV=1, DATA_W=16, N_CH=4, CPOL=1, ch_sel=3 -> sck idles 1, 16 low pulses, cs_n=4'b0111,
//   done at cycle 35 (mode=1); ch_sel=5 would not exist: test ch_sel=3 only.
//  start held high continuously, mode=1 -> back-to-back frames, one IDLE cycle between DONE and LEAD.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared encodings for the SPI frame sequencer: FSM state codes, mode values
// and a small constant helper used when sizing the phase timer.
package spi_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CONV  = 3'd1;
    localparam logic [2:0] ST_LEAD  = 3'd2;
    localparam logic [2:0] ST_SCK_A = 3'd3;
    localparam logic [2:0] ST_SCK_B = 3'd4;
    localparam logic [2:0] ST_TAIL  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic MODE_ADC = 1'b0;
    localparam logic MODE_AMP = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that measures how long each sequencer phase lasts.
// Loading N makes o_expire rise during the N-th cycle after the load edge,
// for exactly one cycle, unless the counter is reloaded first.
module spi_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic         r_run;

    // Count down from load value minus one; the run flag makes expire a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val - W'(1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI frame sequencer: per accepted start, optionally pulses the ADC convert
// strobe, then frames DATA_W SCK cycles under one chip select with load and
// shift strobes for the external shift registers, and finally pulses done.
// Every output is decoded from registered state, so no output glitches.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int   CLK_DIV     = 2,
    parameter int   DATA_W      = 8,
    parameter int   N_CH        = 2,
    parameter int   CONV_CYCLES = 2,
    parameter logic CPOL        = 1'b0,
    localparam int  CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int  BIT_W       = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CH_W-1:0]  ch_sel,
    output logic             busy,
    output logic             adc_conv,
    output logic             spi_sck,
    output logic [N_CH-1:0]  spi_cs_n,
    output logic             load,
    output logic             shift_en,
    output logic [BIT_W-1:0] bit_idx,
    output logic             done
);

    localparam int TMR_W = $clog2(max2(CLK_DIV, CONV_CYCLES)) + 1;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic             r_mode;
    logic [CH_W-1:0]  r_ch;
    logic [BIT_W-1:0] r_bit_idx;
    logic             r_load;
    logic             r_shift_en;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_expire;
    logic             w_accept;
    logic             w_enter_sck_a;
    logic             w_cs_active;

    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_enter_sck_a = (w_state_next == ST_SCK_A) && (r_state != ST_SCK_A);

    spi_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; every timed phase reloads the timer as it is entered.
    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = TMR_W'(CLK_DIV);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_tmr_load = 1'b1;
                    if (mode == MODE_AMP) begin
                        w_state_next = ST_LEAD;
                    end else begin
                        w_state_next = ST_CONV;
                        w_tmr_val    = TMR_W'(CONV_CYCLES);
                    end
                end
            end
            ST_CONV: begin
                if (w_tmr_expire) begin
                    w_state_next = ST_LEAD;
                    w_tmr_load   = 1'b1;
                end
            end
            ST_LEAD: begin
                if (w_tmr_expire) begin
                    w_state_next = ST_SCK_A;
                    w_tmr_load   = 1'b1;
                end
            end
            ST_SCK_A: begin
                if (w_tmr_expire) begin
                    w_state_next = ST_SCK_B;
                    w_tmr_load   = 1'b1;
                end
            end
            ST_SCK_B: begin
                if (w_tmr_expire) begin
                    w_tmr_load   = 1'b1;
                    w_state_next = (r_bit_idx == BIT_W'(DATA_W)) ? ST_TAIL : ST_SCK_A;
                end
            end
            ST_TAIL: begin
                if (w_tmr_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame context and strobes: latch mode/channel on accept, count sample edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_ADC;
            r_ch       <= '0;
            r_bit_idx  <= '0;
            r_load     <= 1'b0;
            r_shift_en <= 1'b0;
        end else begin
            r_load     <= w_accept;
            r_shift_en <= w_enter_sck_a;
            if (w_accept) begin
                r_mode    <= mode;
                r_ch      <= ch_sel;
                r_bit_idx <= '0;
            end else if (w_enter_sck_a && (r_bit_idx != BIT_W'(DATA_W))) begin
                r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy        = (r_state != ST_IDLE);
        adc_conv    = (r_state == ST_CONV) && (r_mode == MODE_ADC);
        spi_sck     = (r_state == ST_SCK_A) ? ~CPOL : CPOL;
        load        = r_load;
        shift_en    = r_shift_en;
        bit_idx     = r_bit_idx;
        done        = (r_state == ST_DONE);
        w_cs_active = (r_state == ST_LEAD) || (r_state == ST_SCK_A) ||
                      (r_state == ST_SCK_B) || (r_state == ST_TAIL);
    end

    // One chip select per slave; out-of-range channel numbers leave all high.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cs
            assign spi_cs_n[gi] = ~(w_cs_active && (r_ch == CH_W'(gi)));
        end
    endgenerate

endmodule
